// File: rtl/pr_int_ctrl.sv
// Processor-bus interrupt controller: syncs NSRC device lines into PENDING, gates by MASK, drives HWInt[7:2].
// Latency: IrqIn -> PENDING in 2 Clk edges after sampling, HWInt one edge after PENDING/MASK update.
// Backpressure: none; single-cycle write strobe, combinational read. Option macro: PR_INT_CTRL_EDGE_EN.
module pr_int_ctrl #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      PrAddr,
  input  logic [31:0]      PrWData,
  input  logic [3:0]       PrMask,
  input  logic             PrWrite,
  output logic [31:0]      PrRData,
  input  logic [NSRC-1:0]  IrqIn,
  output logic [5:0]       HWInt
);

  // Sources live in bits [NSRC-1:0] of 6-bit vectors; everything above is forced to 0.
  localparam logic [6:0] ONE7      = 7'd1;
  localparam logic [5:0] SRC_VALID = 6'((ONE7 << NSRC) - ONE7);

  localparam logic [1:0] SEL_MASK    = 2'd0;
  localparam logic [1:0] SEL_PENDING = 2'd1;
  localparam logic [1:0] SEL_RAW     = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  logic [5:0] irq_ext;
  logic [5:0] s1_q, s1_d;
  logic [5:0] s2_q, s2_d;
  logic [5:0] mask_q, mask_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] hwint_q, hwint_d;
  logic [5:0] set_vec;
  logic [5:0] active;
  logic [2:0] top_idx;
  logic       any_active;
  logic       hit;
  logic [1:0] sel;
  logic       wr_en;
  logic [31:0] status_word;

  // Address low bits, upper write-data bits and upper byte enables carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{PrAddr[1:0], PrWData[31:6], PrMask[3:1]};

  // Widen the raw lines to 6 bits with the unused sources held low.
  always_comb begin
    irq_ext            = '0;
    irq_ext[NSRC-1:0]  = IrqIn;
  end

  assign hit   = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign sel   = PrAddr[3:2];
  assign wr_en = PrWrite && hit && PrMask[0];

`ifdef PR_INT_CTRL_EDGE_EN
  logic [5:0] s3_q, s3_d;

  // Edge mode: a third stage remembers the previous synchronised level.
  always_comb begin
    s3_d    = s2_q;
    set_vec = s2_q & ~s3_q & SRC_VALID;
  end

  // Edge-detect history flop.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s3_q <= '0;
    end else begin
      s3_q <= s3_d;
    end
  end
`else
  // Level mode: a high synchronised line re-asserts its pending bit every cycle.
  always_comb begin
    set_vec = s2_q & SRC_VALID;
  end
`endif

  // Next-state for synchroniser, MASK, PENDING and the registered HWInt image.
  always_comb begin
    s1_d    = irq_ext;
    s2_d    = s1_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    hwint_d = pend_q & mask_q;
    if (wr_en && (sel == SEL_MASK)) begin
      mask_d = PrWData[5:0] & SRC_VALID;
    end
    if (wr_en && (sel == SEL_PENDING)) begin
      pend_d = pend_q & ~PrWData[5:0];
    end
    // Applied after the W1C so a same-cycle set keeps the bit high.
    pend_d = (pend_d | set_vec) & SRC_VALID;
  end

  // State registers; reset wins over any in-flight write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      hwint_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

  // Highest-index active source wins; 7 means nothing is active.
  always_comb begin
    active     = pend_q & mask_q;
    top_idx    = 3'd7;
    any_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (active[i]) begin
        top_idx    = 3'(i);
        any_active = 1'b1;
      end
    end
    status_word = {16'h0, any_active, 4'h0, top_idx, 2'b00, active};
  end

  // Read mux: side-effect free, zero outside the window.
  always_comb begin
    PrRData = 32'h0;
    if (hit) begin
      case (sel)
        SEL_MASK:    PrRData = {26'h0, mask_q};
        SEL_PENDING: PrRData = {26'h0, pend_q};
        SEL_RAW:     PrRData = {26'h0, s2_q};
        SEL_STATUS:  PrRData = status_word;
        default:     PrRData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_int_ctrl.sv
module tb_pr_int_ctrl;
  localparam int          NSRC = 6;
  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] PrAddr;
  logic [31:0] PrWData;
  logic [3:0]  PrMask;
  logic        PrWrite;
  logic [31:0] PrRData;
  logic [NSRC-1:0] IrqIn;
  logic [5:0]  HWInt;

  int checks   = 0;
  int failures = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  pr_int_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Rst(Rst), .PrAddr(PrAddr), .PrWData(PrWData), .PrMask(PrMask),
    .PrWrite(PrWrite), .PrRData(PrRData), .IrqIn(IrqIn), .HWInt(HWInt)
  );

  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%h required=queued_entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", t, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    PrAddr = a;
    #1;
    d = PrRData;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    PrAddr  = a;
    PrWData = d;
    PrMask  = m;
    PrWrite = 1'b1;
    tick();
    PrWrite = 1'b0;
    PrMask  = 4'h0;
  endtask

  task automatic obs_reg(input logic [31:0] a);
    logic [31:0] d;
    rd(a, d);
    pop_chk(d);
  endtask

  task automatic obs_hw();
    pop_chk({26'h0, HWInt});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; PrAddr = '0; PrWData = '0; PrMask = '0; PrWrite = 1'b0; IrqIn = '0;
    tick(); tick();
    Rst = 1'b0;
    tick();

    // 1: reset state
    push_exp("rst_mask", 32'h0);        obs_reg(BASE + 32'h0);
    push_exp("rst_pend", 32'h0);        obs_reg(BASE + 32'h4);
    push_exp("rst_raw", 32'h0);         obs_reg(BASE + 32'h8);
    push_exp("rst_status", 32'h700);    obs_reg(BASE + 32'hC);
    push_exp("rst_hwint", 32'h0);       obs_hw();

    // 2: IrqIn[3] latency chain
    wr(BASE + 32'h0, 32'h3F, 4'h1);
    IrqIn = 6'b001000;
    push_exp("t2_pend_k1", 32'h0);
    push_exp("t2_pend_k2", 32'h08);
    push_exp("t2_hw_k2", 32'h0);
    push_exp("t2_hw_k3", 32'h08);
    push_exp("t2_status", 32'h8308);
    tick(); tick();
    obs_reg(BASE + 32'h4);
    tick();
    obs_reg(BASE + 32'h4);
    obs_hw();
    tick();
    obs_hw();
    obs_reg(BASE + 32'hC);
    IrqIn = '0;
    tick(); tick(); tick(); tick();
    wr(BASE + 32'h4, 32'h3F, 4'h1);
    push_exp("t2_w1c_pend", 32'h0);     obs_reg(BASE + 32'h4);
    tick();
    push_exp("t2_w1c_hw", 32'h0);       obs_hw();

    // 3: priority and re-masking
    IrqIn = 6'b010010;
    tick(); tick(); tick(); tick();
    push_exp("t3_hw", 32'h12);          obs_hw();
    push_exp("t3_status", 32'h8412);    obs_reg(BASE + 32'hC);
    IrqIn = '0;
    tick(); tick(); tick();
    wr(BASE + 32'h0, 32'h02, 4'h1);
    push_exp("t3_hw_w", 32'h12);        obs_hw();
    tick();
    push_exp("t3_hw_w1", 32'h02);       obs_hw();
    push_exp("t3_status2", 32'h8102);   obs_reg(BASE + 32'hC);
    wr(BASE + 32'h4, 32'h3F, 4'h1);
    push_exp("t3_clr", 32'h0);          obs_reg(BASE + 32'h4);

    // 4: latch while masked, unmask, W1C
    wr(BASE + 32'h0, 32'h0, 4'h1);
    IrqIn = 6'b000001;
    tick();
    IrqIn = '0;
    tick(); tick(); tick(); tick();
    push_exp("t4_pend", 32'h1);         obs_reg(BASE + 32'h4);
    push_exp("t4_hw_masked", 32'h0);    obs_hw();
    wr(BASE + 32'h0, 32'h1, 4'h1);
    push_exp("t4_hw_w", 32'h0);         obs_hw();
    tick();
    push_exp("t4_hw_unmask", 32'h1);    obs_hw();
    wr(BASE + 32'h4, 32'h1, 4'h1);
    push_exp("t4_pend_w1c", 32'h0);     obs_reg(BASE + 32'h4);
    push_exp("t4_hw_w1c_w", 32'h1);     obs_hw();
    tick();
    push_exp("t4_hw_w1c", 32'h0);       obs_hw();

    // 5: W1C against a held-high line
    wr(BASE + 32'h0, 32'h04, 4'h1);
    IrqIn = 6'b000100;
    tick(); tick(); tick(); tick();
    push_exp("t5_pend_held", 32'h04);   obs_reg(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h04, 4'h1);
`ifdef PR_INT_CTRL_EDGE_EN
    push_exp("t5_pend_w1c", 32'h0);
    push_exp("t5_pend_later", 32'h0);
    push_exp("t5_hw_later", 32'h0);
`else
    push_exp("t5_pend_w1c", 32'h04);
    push_exp("t5_pend_later", 32'h04);
    push_exp("t5_hw_later", 32'h04);
`endif
    obs_reg(BASE + 32'h4);
    tick(); tick();
    obs_reg(BASE + 32'h4);
    obs_hw();
    IrqIn = '0;
    tick(); tick(); tick();
    IrqIn = 6'b000100;
    tick(); tick(); tick();
    push_exp("t5_pend_redge", 32'h04);  obs_reg(BASE + 32'h4);
    IrqIn = '0;
    tick(); tick(); tick();
    wr(BASE + 32'h4, 32'h3F, 4'h1);
    push_exp("t5_clr", 32'h0);          obs_reg(BASE + 32'h4);

    // 6: dropped writes, out-of-window, unused bits, reset mid-write
    wr(BASE + 32'h0, 32'h3F, 4'h2);
    push_exp("t6_mask_be", 32'h04);     obs_reg(BASE + 32'h0);
    wr(BASE + 32'h10, 32'h3F, 4'hF);
    push_exp("t6_mask_oow", 32'h04);    obs_reg(BASE + 32'h0);
    push_exp("t6_rd_oow", 32'h0);       obs_reg(BASE + 32'h10);
    wr(BASE + 32'h8, 32'h3F, 4'h1);
    push_exp("t6_mask_ro", 32'h04);     obs_reg(BASE + 32'h0);
    wr(BASE + 32'h0, 32'hFFFF_FFFF, 4'h1);
    push_exp("t6_mask_wide", 32'h3F);   obs_reg(BASE + 32'h3);

    IrqIn = 6'b100000;
    tick();
    IrqIn = '0;
    tick(); tick(); tick(); tick();
    push_exp("t6_hw_pre_rst", 32'h20);  obs_hw();
    PrAddr  = BASE;
    PrWData = 32'h1;
    PrMask  = 4'h1;
    PrWrite = 1'b1;
    #2;
    Rst = 1'b1;
    #1;
    push_exp("t6_rst_hw", 32'h0);       obs_hw();
    push_exp("t6_rst_mask", 32'h0);     obs_reg(BASE + 32'h0);
    push_exp("t6_rst_pend", 32'h0);     obs_reg(BASE + 32'h4);
    push_exp("t6_rst_status", 32'h700); obs_reg(BASE + 32'hC);
    PrAddr = BASE;
    tick();
    PrWrite = 1'b0;
    PrMask  = 4'h0;
    Rst     = 1'b0;
    tick();
    push_exp("t6_post_mask", 32'h0);    obs_reg(BASE + 32'h0);
    push_exp("t6_post_hw", 32'h0);      obs_hw();

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
